matmul_seq_ctrl: RTL and testbench
==================================

Name: matmul_seq_ctrl

Overview:
- Sequencer that computes C = A x B for 2x2 matrices by time-sharing one multiply-accumulate unit over 8 cycles.
- Sits between the register/IO front end and the matrix-multiply datapath.
- Takes the operand latching, step scheduling and result commit off the combinational path.
- Interface is a start/busy/done handshake. Results are held in registers until the next completion.

Parameters:
- WIDTH, 8: bit width of each A/B element.
- ACC_W, 2*WIDTH+1: width of each C element. Fixed relation, not to be overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request; sampled only in IDLE.
- a_flat  in  4*WIDTH  A elements, element (r,c) at [WIDTH*(2r+c) +: WIDTH].
- b_flat  in  4*WIDTH  B elements, same packing as a_flat.
- busy  out  1  high while a multiply is in progress.
- done  out  1  one-cycle pulse when c_flat holds a new result.
- c_flat  out  4*ACC_W  C elements, element (r,c) at [ACC_W*(2r+c) +: ACC_W].

Behaviour:
- Reset (rst_n=0, any time including mid-operation):
  - state=IDLE, step=0, accumulator=0, operand registers=0.
  - busy=0, done=0, c_flat=0.
  - The aborted computation leaves no trace.
- FSM states: IDLE, MAC, DONE.
  - IDLE: start=1 at edge T0 latches a_flat/b_flat into internal registers, sets step=0, moves to MAC. busy=1 from T0.
  - MAC: one step per cycle, k=0..7.
    - e=k>>1 selects C element; r=e>>1, c=e&1; t=k&1.
    - Product = A[r][t]*B[t][c].
    - t=0: acc <= product. t=1: shadow[e] <= acc+product.
    - Step k completes at edge T(k+1). At T8, go to DONE.
  - DONE: at edge T9, c_flat <= shadow (all 4 elements at once), done=1 for the cycle after T9, busy=0, go to IDLE.
- Latency: start edge to done-high is 9 edges. busy is high for exactly 9 cycles.
- c_flat holds the previous result throughout MAC and DONE. It never shows partial values.
- start while busy=1 is ignored, with no queuing. Input changes after T0 do not affect the current operation.
- start=1 during the done-high cycle is accepted (FSM is in IDLE), giving back-to-back operation.
- Arithmetic: unsigned by default. Products are 2*WIDTH bits; the sum zero-extends to ACC_W. No overflow is possible: max 2*(2^WIDTH-1)^2 < 2^ACC_W.
- done and busy are registered outputs with no combinational path from start.

Optional Feature:
- Macro: MATMUL_SIGNED_EN.
  - Defined: A/B elements are two's complement. Operands are sign-extended, products are signed, and C elements are signed ACC_W values.
  - Undefined: unsigned arithmetic as described above.
- Timing and handshake are identical in both builds.

Decomposition:
- Package matmul_pkg holds:
  - state encodings IDLE/MAC/DONE;
  - STEPS=8;
  - default WIDTH;
  - ACC_W derivation;
  - index helper constants for the (r,c) packing.
- One sub-module, matmul_mac: combinational, multiplies two WIDTH operands and adds to ACC_W; honours MATMUL_SIGNED_EN.
- The controller owns the FSM, step counter, operand registers, accumulator and shadow/result registers.

Test Plan:
1. Basic multiply: A=[1,2;3,4], B=[5,6;7,8], start pulse -> busy 9 cycles, done 1 cycle, c_flat=[19,22;43,50].
2. Max unsigned: all elements 255 -> every C element = 130050 (0x1FC02), no truncation.
3. Ignored start and back-to-back: start held high through the whole operation with inputs changed mid-run -> result from T0 operands only. A new start on the done cycle with A=I, B=[9,8;7,6] -> second done 9 edges later, c_flat=[9,8;7,6].
4. Reset mid-operation: assert rst_n=0 at step 4 after a prior result [19,22;43,50] -> busy=0, done=0, c_flat=0 immediately. After release, IDLE; the next start computes correctly.
5. Result hold: during MAC, c_flat stays at the previous result every cycle and switches only on the done edge.
6. Signed build (MATMUL_SIGNED_EN): A=[-1,0;0,-1], B=[3,-5;7,2] -> c_flat=[-3,5;-7,-2] (two's complement in ACC_W=17 bits).

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the 2x2 matrix-multiply sequencer.
// Holds the FSM state encoding, step count, default operand width,
// the C-element width derivation and (r,c) packing helpers.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int STEPS     = 8;
  localparam int WIDTH_DEF = 8;

  // Two products of WIDTH-bit operands summed need one extra bit.
  function automatic int calc_acc_w(input int w);
    return 2 * w + 1;
  endfunction

  // Element (r,c) of a packed 2x2 matrix sits at slot 2r+c.
  localparam int unsigned IDX_00 = 0;
  localparam int unsigned IDX_01 = 1;
  localparam int unsigned IDX_10 = 2;
  localparam int unsigned IDX_11 = 3;

  function automatic int unsigned elem_idx(input int unsigned r, input int unsigned c);
    return 2 * r + c;
  endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Start/busy/done handshake and matrix buses for matmul_seq_ctrl.
//   start  : request, sampled only while the sequencer is idle
//   a_flat : A elements, (r,c) at [WIDTH*(2r+c) +: WIDTH]
//   b_flat : B elements, same packing
//   busy   : high while a multiply is in progress
//   done   : one-cycle pulse when c_flat holds a new result
//   c_flat : C elements, (r,c) at [ACC_W*(2r+c) +: ACC_W]
// Modports: master (front end), slave (sequencer).
interface matmul_seq_ctrl_if
  import matmul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  localparam int ACC_W = calc_acc_w(WIDTH);

  logic                 start;
  logic [4*WIDTH-1:0]   a_flat;
  logic [4*WIDTH-1:0]   b_flat;
  logic                 busy;
  logic                 done;
  logic [4*ACC_W-1:0]   c_flat;

  modport master (
    output start, a_flat, b_flat,
    input  busy, done, c_flat
  );

  modport slave (
    input  start, a_flat, b_flat,
    output busy, done, c_flat
  );

endinterface

// File: rtl/matmul_mac.sv
// Combinational multiply-accumulate: sum_o = addend_i + a_i * b_i.
//   a_i, b_i : WIDTH-bit operands
//   addend_i : ACC_W-bit running sum
//   sum_o    : ACC_W-bit result
// Build option MATMUL_SIGNED_EN: operands are two's complement and are
// sign-extended; otherwise they are zero-extended (unsigned).
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]                 a_i,
  input  logic [WIDTH-1:0]                 b_i,
  input  logic [calc_acc_w(WIDTH)-1:0]     addend_i,
  output logic [calc_acc_w(WIDTH)-1:0]     sum_o
);
  localparam int ACC_W = calc_acc_w(WIDTH);

  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] b_ext;
  logic [ACC_W-1:0] product;

`ifdef MATMUL_SIGNED_EN
  assign a_ext = {{(ACC_W-WIDTH){a_i[WIDTH-1]}}, a_i};
  assign b_ext = {{(ACC_W-WIDTH){b_i[WIDTH-1]}}, b_i};
  // Low ACC_W bits of a modular product equal the signed product bits.
  assign product = $signed(a_ext) * $signed(b_ext);
`else
  assign a_ext = {{(ACC_W-WIDTH){1'b0}}, a_i};
  assign b_ext = {{(ACC_W-WIDTH){1'b0}}, b_i};
  assign product = a_ext * b_ext;
`endif

  assign sum_o = addend_i + product;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// 2x2 matrix multiply sequencer: C = A x B using one shared MAC over
// 8 steps, then commits all four C elements at once.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : matmul_seq_ctrl_if.slave (start/a_flat/b_flat in,
//           busy/done/c_flat out, all outputs registered)
// Build option MATMUL_SIGNED_EN selects two's complement arithmetic.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  matmul_seq_ctrl_if.slave   bus
);
  localparam int ACC_W = calc_acc_w(WIDTH);

  state_e                    state_q, state_d;
  logic [2:0]                step_q, step_d;
  logic [4*WIDTH-1:0]        a_q, a_d;
  logic [4*WIDTH-1:0]        b_q, b_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [3:0][ACC_W-1:0]     shadow_q, shadow_d;
  logic [4*ACC_W-1:0]        c_q, c_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  // Step k: e = k>>1 -> (r,c) = (k[2],k[1]); t = k[0].
  // A[r][t] slot = {k[2],k[0]}, B[t][c] slot = {k[0],k[1]}.
  logic [1:0]                a_idx, b_idx;
  logic [WIDTH-1:0]          a_op, b_op;
  logic [ACC_W-1:0]          mac_add, mac_sum;

  assign a_idx   = {step_q[2], step_q[0]};
  assign b_idx   = {step_q[0], step_q[1]};
  assign a_op    = a_q[WIDTH*int'(a_idx) +: WIDTH];
  assign b_op    = b_q[WIDTH*int'(b_idx) +: WIDTH];
  assign mac_add = step_q[0] ? acc_q : '0;

  matmul_mac #(.WIDTH(WIDTH)) u_mac (
    .a_i      (a_op),
    .b_i      (b_op),
    .addend_i (mac_add),
    .sum_o    (mac_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      step_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      c_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      c_q      <= c_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    shadow_d = shadow_q;
    c_d      = c_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a_flat;
          b_d     = bus.b_flat;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        if (!step_q[0]) begin
          acc_d = mac_sum;
        end else begin
          shadow_d[step_q[2:1]] = mac_sum;
        end
        step_d = step_q + 3'd1;
        if (step_q == 3'(STEPS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Commit all four elements together so c_flat never shows partials.
        c_d     = shadow_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.c_flat = c_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
module tb_matmul_seq_ctrl;
  localparam int W  = 8;
  localparam int AW = 2 * W + 1;

  typedef struct {
    logic [4*W-1:0]  a;
    logic [4*W-1:0]  b;
    logic [4*AW-1:0] c;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [4*AW-1:0] prev_c;

  matmul_seq_ctrl_if #(.WIDTH(W)) bus ();

  matmul_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4*W-1:0] pk_ab(input int m00, input int m01,
                                           input int m10, input int m11);
    return {W'(m11), W'(m10), W'(m01), W'(m00)};
  endfunction

  function automatic logic [4*AW-1:0] pk_c(input int m00, input int m01,
                                           input int m10, input int m11);
    return {AW'(m11), AW'(m10), AW'(m01), AW'(m00)};
  endfunction

  task automatic chk(input string name, input logic [4*AW-1:0] act,
                     input logic [4*AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drives start, then follows the op to its done cycle.
  // Returns positioned at the negedge of the done-high cycle.
  task automatic run_op(input vec_t v, input bit hold_start);
    bus.start  = 1'b1;
    bus.a_flat = v.a;
    bus.b_flat = v.b;
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (!hold_start) bus.start = 1'b0;
      if (i == 0) begin
        bus.a_flat = ~v.a;
        bus.b_flat = ~v.b;
      end
      chk("busy_during_op", {67'd0, bus.busy}, 68'd1);
      chk("done_during_op", {67'd0, bus.done}, 68'd0);
      chk("c_hold_during_op", bus.c_flat, prev_c);
    end
    @(negedge clk);
    chk("done_pulse", {67'd0, bus.done}, 68'd1);
    chk("busy_after_op", {67'd0, bus.busy}, 68'd0);
    chk("c_result", bus.c_flat, v.c);
    prev_c = v.c;
  endtask

  task automatic idle_gap();
    bus.start = 1'b0;
    @(negedge clk);
    chk("gap_done_low", {67'd0, bus.done}, 68'd0);
    chk("gap_busy_low", {67'd0, bus.busy}, 68'd0);
    chk("gap_c_hold", bus.c_flat, prev_c);
  endtask

  vec_t tbl[$];
  vec_t v_basic, v_b2b;

  initial begin
    checks     = 0;
    failures   = 0;
    prev_c     = '0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.a_flat = '0;
    bus.b_flat = '0;

    v_basic = '{a: pk_ab(1, 2, 3, 4), b: pk_ab(5, 6, 7, 8), c: pk_c(19, 22, 43, 50)};
    v_b2b   = '{a: pk_ab(1, 0, 0, 1), b: pk_ab(9, 8, 7, 6), c: pk_c(9, 8, 7, 6)};

    tbl.push_back(v_basic);
    tbl.push_back('{a: pk_ab(0, 1, 1, 0), b: pk_ab(2, 3, 4, 5), c: pk_c(4, 5, 2, 3)});
    tbl.push_back('{a: pk_ab(10, 0, 0, 20), b: pk_ab(3, 4, 5, 6), c: pk_c(30, 40, 100, 120)});
`ifdef MATMUL_SIGNED_EN
    tbl.push_back('{a: pk_ab(-1, 0, 0, -1), b: pk_ab(3, -5, 7, 2), c: pk_c(-3, 5, -7, -2)});
    tbl.push_back('{a: pk_ab(-2, 3, 4, -5), b: pk_ab(6, -7, -8, 9), c: pk_c(-36, 41, 64, -73)});
`else
    tbl.push_back('{a: pk_ab(255, 255, 255, 255), b: pk_ab(255, 255, 255, 255),
                    c: pk_c(130050, 130050, 130050, 130050)});
    tbl.push_back('{a: pk_ab(0, 0, 0, 0), b: pk_ab(255, 1, 2, 3), c: pk_c(0, 0, 0, 0)});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_busy", {67'd0, bus.busy}, 68'd0);
    chk("reset_done", {67'd0, bus.done}, 68'd0);
    chk("reset_c", bus.c_flat, 68'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven operations
    foreach (tbl[i]) begin
      run_op(tbl[i], 1'b0);
      idle_gap();
    end

    // start held high with inputs scrambled mid-run, then back-to-back start
    run_op(v_basic, 1'b1);
    run_op(v_b2b, 1'b0);
    idle_gap();

    // Reset during step 4 after a known prior result
    run_op(v_basic, 1'b0);
    idle_gap();
    bus.start  = 1'b1;
    bus.a_flat = v_b2b.a;
    bus.b_flat = v_b2b.b;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("pre_reset_busy", {67'd0, bus.busy}, 68'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", {67'd0, bus.busy}, 68'd0);
    chk("midreset_done", {67'd0, bus.done}, 68'd0);
    chk("midreset_c", bus.c_flat, 68'd0);
    prev_c = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_gap();
    run_op(v_basic, 1'b0);
    idle_gap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
